// File: rtl/rot_unit_xlen.sv
// PowerPC rotate/mask/shift execution unit with XLEN-wide datapath, CR0/CA generation
// and a STAGES-deep valid/ready pipeline with flush.
module rot_unit_xlen #(
    parameter int XLEN        = 32,
    parameter int RS_ID_WIDTH = 5,
    parameter int STAGES      = 3,
    localparam int SH_W       = $clog2(XLEN)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   input_valid,
    output logic                   input_ready,
    input  logic [RS_ID_WIDTH-1:0] rs_id_in,
    input  logic [4:0]             result_reg_addr_in,
    input  logic [XLEN-1:0]        op1,
    input  logic [XLEN-1:0]        op2,
    input  logic [XLEN-1:0]        target,
    input  logic                   xer_so,
    input  logic                   shift,
    input  logic                   left,
    input  logic                   sign_extend,
    input  logic                   mask_insert,
    input  logic                   alter_cr0,
    input  logic [SH_W-1:0]        mb,
    input  logic [SH_W-1:0]        me,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [RS_ID_WIDTH-1:0] rs_id_out,
    output logic [4:0]             result_reg_addr_out,
    output logic [XLEN-1:0]        result,
    output logic [3:0]             cr0,
    output logic                   cr0_valid,
    output logic                   ca,
    output logic                   ca_valid
);

    localparam logic [XLEN-1:0] ONES = '1;

    typedef struct packed {
        logic [RS_ID_WIDTH-1:0] rs_id;
        logic [4:0]             rd;
        logic [XLEN-1:0]        res;
        logic [3:0]             cr0;
        logic                   cr0_v;
        logic                   ca;
        logic                   ca_v;
    } stage_t;

    logic [SH_W:0]   n;
    logic [SH_W-1:0] amt;
    logic [SH_W:0]   ramt;
    logic            overshift;
    logic [XLEN-1:0] rot;
    logic [XLEN-1:0] mask;
    logic [XLEN-1:0] low_bits;
    logic [XLEN-1:0] res_c;
    logic            ca_c;
    stage_t          stage_d;

    stage_t          pipe [STAGES];
    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] ld;
    logic            ld_acc;

    logic            unused_op2_hi;
    assign unused_op2_hi = ^op2[XLEN-1:SH_W+1];

    // All arithmetic is done before the first register; later stages only carry the payload.
    always_comb begin
        n         = op2[SH_W:0];
        amt       = n[SH_W-1:0];
        overshift = n[SH_W];
        ramt      = (SH_W+1)'(XLEN) - {1'b0, amt};
        rot       = (op1 << amt) | (op1 >> ramt);
        low_bits  = ~(ONES << amt);
        mask      = '0;
        res_c     = '0;
        ca_c      = 1'b0;

        // mb/me use big-endian numbering: position i maps to bit XLEN-1-i.
        for (int unsigned i = 0; i < XLEN; i++) begin
            if (mb <= me)
                mask[XLEN-1-i] = (SH_W'(i) >= mb) && (SH_W'(i) <= me);
            else
                mask[XLEN-1-i] = (SH_W'(i) >= mb) || (SH_W'(i) <= me);
        end

        if (!shift) begin
            res_c = mask_insert ? ((rot & mask) | (target & ~mask)) : (rot & mask);
        end else if (left) begin
            res_c = overshift ? '0 : (op1 << amt);
        end else if (sign_extend) begin
            if (overshift) begin
                res_c = {XLEN{op1[XLEN-1]}};
                ca_c  = op1[XLEN-1] & (|op1);
            end else begin
                res_c = $signed(op1) >>> amt;
                ca_c  = op1[XLEN-1] & (|(op1 & low_bits));
            end
        end else begin
            res_c = overshift ? '0 : (op1 >> amt);
        end

        stage_d.rs_id = rs_id_in;
        stage_d.rd    = result_reg_addr_in;
        stage_d.res   = res_c;
        stage_d.cr0   = {res_c[XLEN-1], ~res_c[XLEN-1] & (|res_c), ~(|res_c), xer_so};
        stage_d.cr0_v = alter_cr0;
        stage_d.ca    = ca_c;
        stage_d.ca_v  = shift & ~left & sign_extend;
    end

    // A stage may load if it or any stage below it is empty, or the consumer is taking the output.
    always_comb begin
        ld_acc = output_ready;
        ld     = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            ld_acc            = ld_acc | ~vld[STAGES-1-k];
            ld[STAGES-1-k]    = ld_acc;
        end
    end

    assign input_ready = ld[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
            for (int unsigned i = 0; i < STAGES; i++)
                pipe[i] <= '0;
        end else if (flush) begin
            vld <= '0;
        end else begin
            if (ld[0]) begin
                vld[0] <= input_valid;
                if (input_valid)
                    pipe[0] <= stage_d;
            end
            for (int unsigned i = 1; i < STAGES; i++) begin
                if (ld[i]) begin
                    vld[i] <= vld[i-1];
                    if (vld[i-1])
                        pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign output_valid        = vld[STAGES-1];
    assign rs_id_out           = pipe[STAGES-1].rs_id;
    assign result_reg_addr_out = pipe[STAGES-1].rd;
    assign result              = pipe[STAGES-1].res;
    assign cr0                 = pipe[STAGES-1].cr0;
    assign cr0_valid           = pipe[STAGES-1].cr0_v;
    assign ca                  = pipe[STAGES-1].ca;
    assign ca_valid            = pipe[STAGES-1].ca_v;

endmodule

// File: tb/tb_rot_unit_xlen.sv
// Self-checking bench for rot_unit_xlen: a 32-bit/3-stage instance and a 64-bit/2-stage
// instance, checked against a bit-level reference model of the rotate/shift rules.
module tb_rot_unit_xlen;

    typedef struct packed {
        logic [63:0] a, b, t;
        logic        so, sh, lf, se, mi, acr;
        logic [5:0]  mb, me;
        logic [4:0]  id, rd;
    } op_t;

    typedef struct packed {
        logic [63:0] res;
        logic [3:0]  cr0;
        logic        ca, cav, crv;
        logic [4:0]  id, rd;
    } exp_t;

    int errors = 0;
    int checks = 0;
    exp_t sb [$];

    logic clk = 1'b0;
    logic rst, flush;
    logic xer_so, shift, left, sign_extend, mask_insert, alter_cr0;
    logic [4:0] rs_id_in, result_reg_addr_in;

    logic        input_valid, input_ready, output_valid, output_ready;
    logic [31:0] op1, op2, target, result;
    logic [4:0]  mb, me, rs_id_out, result_reg_addr_out;
    logic [3:0]  cr0;
    logic        cr0_valid, ca, ca_valid;

    logic        input_valid_w, w_input_ready, w_output_valid;
    logic [63:0] op1_w, op2_w, target_w, w_result;
    logic [5:0]  mb_w, me_w;
    logic [4:0]  w_rs_id_out, w_rd_out;
    logic [3:0]  w_cr0;
    logic        w_cr0_valid, w_ca, w_ca_valid;

    always #5 clk = ~clk;

    rot_unit_xlen #(.XLEN(32), .RS_ID_WIDTH(5), .STAGES(3)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .input_valid(input_valid), .input_ready(input_ready),
        .rs_id_in(rs_id_in), .result_reg_addr_in(result_reg_addr_in),
        .op1(op1), .op2(op2), .target(target), .xer_so(xer_so),
        .shift(shift), .left(left), .sign_extend(sign_extend),
        .mask_insert(mask_insert), .alter_cr0(alter_cr0), .mb(mb), .me(me),
        .output_valid(output_valid), .output_ready(output_ready),
        .rs_id_out(rs_id_out), .result_reg_addr_out(result_reg_addr_out),
        .result(result), .cr0(cr0), .cr0_valid(cr0_valid), .ca(ca), .ca_valid(ca_valid)
    );

    rot_unit_xlen #(.XLEN(64), .RS_ID_WIDTH(5), .STAGES(2)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .input_valid(input_valid_w), .input_ready(w_input_ready),
        .rs_id_in(rs_id_in), .result_reg_addr_in(result_reg_addr_in),
        .op1(op1_w), .op2(op2_w), .target(target_w), .xer_so(xer_so),
        .shift(shift), .left(left), .sign_extend(sign_extend),
        .mask_insert(mask_insert), .alter_cr0(alter_cr0), .mb(mb_w), .me(me_w),
        .output_valid(w_output_valid), .output_ready(1'b1),
        .rs_id_out(w_rs_id_out), .result_reg_addr_out(w_rd_out),
        .result(w_result), .cr0(w_cr0), .cr0_valid(w_cr0_valid), .ca(w_ca), .ca_valid(w_ca_valid)
    );

    // Reference: each result bit is derived from the architectural definition of the op.
    function automatic exp_t model(int w, op_t o);
        exp_t e;
        int n, src;
        logic sign, mk, any;
        e = '0;
        n = (w == 32) ? int'(o.b[5:0]) : int'(o.b[6:0]);
        sign = o.a[w-1];
        if (!o.sh) begin
            for (int i = 0; i < w; i++) begin
                src = (i + n) % w;
                if (int'(o.mb) <= int'(o.me)) mk = (i >= int'(o.mb)) && (i <= int'(o.me));
                else                          mk = (i >= int'(o.mb)) || (i <= int'(o.me));
                e.res[w-1-i] = mk ? o.a[w-1-src] : (o.mi & o.t[w-1-i]);
            end
        end else if (o.lf) begin
            for (int i = 0; i < w; i++)
                e.res[i] = (i >= n) ? o.a[i-n] : 1'b0;
        end else begin
            for (int i = 0; i < w; i++)
                e.res[i] = (i + n < w) ? o.a[i+n] : (o.se & sign);
            if (o.se) begin
                any = 1'b0;
                for (int j = 0; j < w && j < n; j++) any = any | o.a[j];
                e.ca  = sign & any;
                e.cav = 1'b1;
            end
        end
        e.cr0 = {e.res[w-1], !e.res[w-1] && (e.res != 0), e.res == 0, o.so};
        e.crv = o.acr;
        e.id  = o.id;
        e.rd  = o.rd;
        return e;
    endfunction

    function automatic op_t rand_op(int w);
        op_t o;
        o.a = {$urandom, $urandom};
        case ($urandom % 5)
            0: o.a = '0;
            1: o.a = 64'(1) << (w - 1);
            default: ;
        endcase
        if (w == 32) o.a[63:32] = '0;
        o.b  = ({$urandom, $urandom} << 7) | 64'($urandom_range(0, 2 * w - 1));
        o.t  = {$urandom, $urandom};
        o.so = 1'($urandom);  o.sh = 1'($urandom); o.lf = 1'($urandom);
        o.se = 1'($urandom);  o.mi = 1'($urandom); o.acr = 1'($urandom);
        o.mb = 6'($urandom_range(0, w - 1));
        o.me = 6'($urandom_range(0, w - 1));
        o.id = 5'($urandom);
        o.rd = 5'($urandom);
        return o;
    endfunction

    function automatic op_t mk(logic [63:0] a, int n, logic [63:0] t, logic sh, logic lf,
                               logic se, logic mi, int mbv, int mev, logic so);
        op_t o;
        o = '0;
        o.a = a; o.b = 64'(n); o.t = t; o.so = so;
        o.sh = sh; o.lf = lf; o.se = se; o.mi = mi; o.acr = 1'b1;
        o.mb = 6'(mbv); o.me = 6'(mev); o.id = 5'd3; o.rd = 5'd7;
        return o;
    endfunction

    task automatic put_ctl(op_t o);
        xer_so = o.so; shift = o.sh; left = o.lf; sign_extend = o.se;
        mask_insert = o.mi; alter_cr0 = o.acr; rs_id_in = o.id; result_reg_addr_in = o.rd;
    endtask

    task automatic put32(op_t o);
        put_ctl(o);
        op1 = o.a[31:0]; op2 = o.b[31:0]; target = o.t[31:0];
        mb = o.mb[4:0]; me = o.me[4:0];
    endtask

    task automatic put64(op_t o);
        put_ctl(o);
        op1_w = o.a; op2_w = o.b; target_w = o.t; mb_w = o.mb; me_w = o.me;
    endtask

    // Drives one op into the 32-bit unit and captures its output; lat = -1 if never accepted.
    task automatic issue32(input op_t o, output int lat, output logic [31:0] r, output logic [3:0] c,
                           output logic cv, output logic cao, output logic cav);
        logic acc;
        acc = 1'b0;
        put32(o);
        input_valid = 1'b1;
        for (int t = 0; t < 20 && !acc; t++) begin
            @(negedge clk); acc = input_ready;
            @(posedge clk); #1;
        end
        input_valid = 1'b0;
        lat = 1;
        while (!output_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        if (!acc) lat = -1;
        r = result; c = cr0; cv = cr0_valid; cao = ca; cav = ca_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #23;
        checks++;
        if ({output_valid, result, cr0, ca, cr0_valid, ca_valid, rs_id_out, result_reg_addr_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b result=%h cr0=%b rs_id=%0d rd=%0d, required all 0",
                     output_valid, result, cr0, rs_id_out, result_reg_addr_out);
        end
        checks++;
        if (input_ready !== 1'b1) begin
            errors++; $display("FAIL reset_input_ready: got %b required 1", input_ready);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rotate();
        int lat; logic [31:0] r; logic [3:0] c; logic cv, cao, cav;
        issue32(mk(32'h12345678, 8, 0, 0, 0, 0, 0, 24, 31, 0), lat, r, c, cv, cao, cav);
        checks++;
        if (lat != 3) begin errors++; $display("FAIL rotate_latency: got %0d required 3", lat); end
        checks++;
        if ({r, c, cv, cav} !== {32'h00000012, 4'b0100, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL rotate_rlwinm: got result=%h cr0=%b cr0_valid=%b ca_valid=%b required 00000012 0100 1 0",
                     r, c, cv, cav);
        end
    endtask

    task automatic test_mask_insert();
        int lat; logic [31:0] r; logic [3:0] c; logic cv, cao, cav;
        issue32(mk(32'h000000AB, 0, 64'hFFFF0000, 0, 0, 0, 1, 24, 31, 0), lat, r, c, cv, cao, cav);
        checks++;
        if (r !== 32'hFFFF00AB) begin errors++; $display("FAIL mask_insert: got %h required FFFF00AB", r); end
        issue32(mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 28, 3, 0), lat, r, c, cv, cao, cav);
        checks++;
        if (r !== 32'hF000000F) begin errors++; $display("FAIL wrap_mask: got %h required F000000F", r); end
    endtask

    task automatic test_shifts();
        int lat; logic [31:0] r; logic [3:0] c; logic cv, cao, cav;
        logic [31:0] sa [3] = '{32'h80000001, 32'h80000000, 32'h80000000};
        int          sn [3] = '{1, 4, 40};
        logic [31:0] sr [3] = '{32'hC0000000, 32'hF8000000, 32'hFFFFFFFF};
        logic        sc [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            issue32(mk(64'(sa[k]), sn[k], 0, 1, 0, 1, 0, 0, 0, 0), lat, r, c, cv, cao, cav);
            checks++;
            if ({r, cao, cav} !== {sr[k], sc[k], 1'b1}) begin
                errors++;
                $display("FAIL sraw_%0d: got result=%h ca=%b ca_valid=%b required %h %b 1",
                         k, r, cao, cav, sr[k], sc[k]);
            end
        end
        issue32(mk(32'h1, 32, 0, 1, 1, 0, 0, 0, 0, 0), lat, r, c, cv, cao, cav);
        checks++;
        if ({r, c, cav} !== {32'h0, 4'b0010, 1'b0}) begin
            errors++; $display("FAIL slw_overshift: got result=%h cr0=%b ca_valid=%b required 0 0010 0", r, c, cav);
        end
        issue32(mk(32'h80000000, 31, 0, 1, 0, 0, 0, 0, 0, 1), lat, r, c, cv, cao, cav);
        checks++;
        if ({r, c, cao, cav} !== {32'h1, 4'b0101, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL srw_so: got result=%h cr0=%b ca=%b ca_valid=%b required 00000001 0101 0 0", r, c, cao, cav);
        end
    endtask

    task automatic test_back_to_back();
        op_t o; exp_t e;
        int accepted, got;
        logic take, stall;
        logic [48:0] snap, psnap;
        sb.delete();
        accepted = 0; got = 0; stall = 1'b0; psnap = '0;
        output_ready = 1'b0;
        o = rand_op(32); o.id = 5'd10; put32(o); input_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            snap = {result, cr0, ca, ca_valid, cr0_valid, rs_id_out, result_reg_addr_out};
            if (stall) begin
                checks++;
                if (snap !== psnap) begin errors++; $display("FAIL b2b_hold: got %h required %h", snap, psnap); end
            end
            if (cyc == 4) begin
                checks++;
                if (accepted != 3 || input_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_full: accepted=%0d input_ready=%b required 3 0", accepted, input_ready);
                end
            end
            if (output_valid && output_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL b2b_extra: output rs_id=%0d with none pending", rs_id_out);
                end else begin
                    e = sb.pop_front();
                    if (snap !== {e.res[31:0], e.cr0, e.ca, e.cav, e.crv, e.id, e.rd}) begin
                        errors++;
                        $display("FAIL b2b_data: got %h required %h", snap,
                                 {e.res[31:0], e.cr0, e.ca, e.cav, e.crv, e.id, e.rd});
                    end
                end
                got++;
            end
            take = input_valid && input_ready;
            if (take) begin sb.push_back(model(32, o)); accepted++; end
            stall = output_valid && !output_ready;
            psnap = snap;
            @(posedge clk); #1;
            if (take) begin
                if (accepted < 6) begin o = rand_op(32); o.id = 5'(10 + accepted); put32(o); end
                else input_valid = 1'b0;
            end
            if (cyc == 4) output_ready = 1'b1;
        end
        input_valid = 1'b0;
        checks++;
        if (got != 6) begin errors++; $display("FAIL b2b_count: got %0d outputs required 6", got); end
    endtask

    task automatic test_random();
        op_t o; exp_t e;
        int issued, got;
        logic take, stall;
        logic [48:0] snap, psnap;
        sb.delete();
        issued = 0; got = 0; stall = 1'b0; psnap = '0; o = '0;
        for (int cyc = 0; cyc < 3000 && got < 300; cyc++) begin
            @(negedge clk);
            snap = {result, cr0, ca, ca_valid, cr0_valid, rs_id_out, result_reg_addr_out};
            if (stall) begin
                checks++;
                if (snap !== psnap) begin errors++; $display("FAIL rand_hold: got %h required %h", snap, psnap); end
            end
            if (output_valid && output_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rand_extra: output rs_id=%0d with none pending", rs_id_out);
                end else begin
                    e = sb.pop_front();
                    if (snap !== {e.res[31:0], e.cr0, e.ca, e.cav, e.crv, e.id, e.rd}) begin
                        errors++;
                        $display("FAIL rand_data: got %h required %h", snap,
                                 {e.res[31:0], e.cr0, e.ca, e.cav, e.crv, e.id, e.rd});
                    end
                end
                got++;
            end
            take = input_valid && input_ready;
            if (take) sb.push_back(model(32, o));
            stall = output_valid && !output_ready;
            psnap = snap;
            @(posedge clk); #1;
            if (take || !input_valid) begin
                if (issued < 300 && ($urandom % 4) != 0) begin
                    o = rand_op(32); put32(o); input_valid = 1'b1; issued++;
                end else input_valid = 1'b0;
            end
            output_ready = (($urandom % 4) != 0);
        end
        input_valid = 1'b0; output_ready = 1'b1;
        checks++;
        if (got != 300) begin errors++; $display("FAIL rand_count: got %0d outputs required 300", got); end
    endtask

    task automatic test_flush();
        int lat, seen; logic [31:0] r; logic [3:0] c; logic cv, cao, cav;
        output_ready = 1'b1;
        put32(mk(32'h11, 0, 0, 0, 0, 0, 0, 0, 31, 0)); input_valid = 1'b1;
        @(posedge clk); #1;
        put32(mk(32'h22, 0, 0, 0, 0, 0, 0, 0, 31, 0));
        @(posedge clk); #1;
        put32(mk(32'h33, 0, 0, 0, 0, 0, 0, 0, 31, 0)); flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; input_valid = 1'b0;
        checks++;
        if (output_valid !== 1'b0 || input_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: output_valid=%b input_ready=%b required 0 1", output_valid, input_ready);
        end
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (output_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_drop: %0d outputs emerged required 0", seen); end
        issue32(mk(32'h12345678, 8, 0, 0, 0, 0, 0, 24, 31, 0), lat, r, c, cv, cao, cav);
        checks++;
        if (lat != 3 || r !== 32'h12) begin
            errors++; $display("FAIL flush_after: latency=%0d result=%h required 3 00000012", lat, r);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        output_ready = 1'b0;
        put32(mk(32'h12345678, 8, 0, 0, 0, 0, 0, 24, 31, 1)); input_valid = 1'b1;
        @(posedge clk); #1;
        put32(mk(32'h0F0F0F0F, 4, 0, 0, 0, 0, 0, 0, 31, 0));
        @(posedge clk); #1;
        input_valid = 1'b0;
        for (int k = 0; k < 10 && !output_valid; k++) begin @(posedge clk); #1; end
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({output_valid, result, cr0, ca, cr0_valid, ca_valid, rs_id_out, result_reg_addr_out} !== '0
            || input_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b result=%h cr0=%b rs_id=%0d rd=%0d ready=%b, required 0s and ready 1",
                     output_valid, result, cr0, rs_id_out, result_reg_addr_out, input_ready);
        end
        @(negedge clk); rst = 1'b0; output_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (output_valid) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL reset_mid_drop: %0d outputs emerged required 0", seen); end
    endtask

    task automatic test_xlen64();
        op_t o; exp_t e;
        int lat; logic acc;
        logic [63:0] want;
        for (int k = 0; k < 41; k++) begin
            if (k == 0) o = mk(64'h0123456789ABCDEF, 4, 0, 0, 0, 0, 0, 0, 63, 0);
            else        o = rand_op(64);
            e = model(64, o);
            want = (k == 0) ? 64'h123456789ABCDEF0 : e.res;
            put64(o); input_valid_w = 1'b1; acc = 1'b0;
            for (int t = 0; t < 20 && !acc; t++) begin
                @(negedge clk); acc = w_input_ready;
                @(posedge clk); #1;
            end
            input_valid_w = 1'b0;
            lat = 1;
            while (!w_output_valid && lat < 20) begin @(posedge clk); #1; lat++; end
            checks++;
            if (!acc || lat != 2) begin
                errors++; $display("FAIL x64_latency_%0d: accepted=%b latency=%0d required 1 2", k, acc, lat);
            end
            checks++;
            if ({w_result, w_cr0, w_ca, w_ca_valid, w_cr0_valid, w_rs_id_out, w_rd_out}
                !== {want, e.cr0, e.ca, e.cav, e.crv, e.id, e.rd}) begin
                errors++;
                $display("FAIL x64_data_%0d: got result=%h cr0=%b ca=%b cav=%b required %h %b %b %b",
                         k, w_result, w_cr0, w_ca, w_ca_valid, want, e.cr0, e.ca, e.cav);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        input_valid = 1'b0; output_ready = 1'b1; input_valid_w = 1'b0;
        put32('0); put64('0);
        test_reset();
        test_rotate();
        test_mask_insert();
        test_shifts();
        test_back_to_back();
        test_random();
        test_flush();
        test_reset_mid();
        test_xlen64();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rot_unit_xlen.md
Name: rot_unit_xlen

Overview:
- Parametrised successor of the 32-bit rotate unit. Executes PowerPC rotate-and-mask, mask-insert and shift instructions (rlwinm/rlwimi/rlwnm, slw/srw/sraw/srawi, and 64-bit analogues when XLEN=64).
- Configurable pipeline depth, full valid/ready back-pressure and a flush input.
- Computes CR0 field values and XER[CA] in-unit. Sits behind a reservation station and returns results to the writeback/CDB arbiter.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64.
- RS_ID_WIDTH, 5, width of reservation-station tag.
- STAGES, 3, fixed latency in cycles from accept to output_valid; legal 1..4.
- SH_W, $clog2(XLEN), derived width of the rotate amount; not overridable.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous pipeline kill
- input_valid  in  1  operation offered
- input_ready  out  1  operation accepted when input_valid & input_ready
- rs_id_in  in  RS_ID_WIDTH  tag
- result_reg_addr_in  in  5  destination GPR
- op1  in  XLEN  source value (RS)
- op2  in  XLEN  shift/rotate amount; low SH_W+1 bits used
- target  in  XLEN  old RA value, used by mask insert
- xer_so  in  1  current XER[SO]
- shift, left, sign_extend, mask_insert, alter_cr0  in  1 each  decoded controls
- mb, me  in  SH_W each  mask begin/end, big-endian bit numbering (bit 0 = MSB)
- output_valid  out  1  result available
- output_ready  in  1  consumer accepts
- rs_id_out  out  RS_ID_WIDTH
- result_reg_addr_out  out  5
- result  out  XLEN
- cr0  out  4  {LT,GT,EQ,SO}
- cr0_valid  out  1  equals alter_cr0 of the op
- ca  out  1  new XER[CA]
- ca_valid  out  1  high only for algebraic right shifts

Behaviour:
- Reset (async): all stage valids 0; output_valid 0; result, cr0, ca, cr0_valid, ca_valid, rs_id_out, result_reg_addr_out all 0.
- Let n = op2[XLEN-SH_W-1 : XLEN-1], an (SH_W+1)-bit value. Overshift = (n >= XLEN).
- Rotate (shift=0): r = rotl(op1, n mod XLEN).
  - mask bit i = (mb<=i<=me) if mb<=me, else (i>=mb)|(i<=me).
  - result = r&mask, or (r&mask)|(target&~mask) when mask_insert.
- Shift left: overshift -> 0; else op1 << n.
- Shift right logical: overshift -> 0; else op1 >> n.
- Shift right algebraic (sign_extend=1, left=0):
  - Overshift -> all bits = op1[0], ca = op1[0] & (op1 != 0).
  - Otherwise -> arithmetic shift, ca = op1[0] & (any bit shifted out != 0).
  - ca_valid=1. In all other modes ca=0 and ca_valid=0.
- cr0: LT/GT/EQ from result interpreted as signed XLEN; SO = xer_so sampled with the op. Computed even when alter_cr0=0.
- Latency: exactly STAGES cycles from the accept edge to output_valid=1 when there is no back-pressure. Throughput is 1 op per cycle. Internal retiming across stages is free; only latency and ordering are fixed.
- Handshake:
  - Each stage loads when it is empty or when its downstream stage is loading; the last stage loads when empty or when output_ready.
  - input_ready = first stage empty or first stage advancing. No combinational path from input_valid to input_ready.
  - While output_valid & !output_ready, all outputs are held stable.
  - At most STAGES ops are in flight. In-order delivery; no drops or duplicates.
- Flush:
  - Next edge clears every stage valid and output_valid.
  - An op presented in the flush cycle is discarded, even if input_ready=1.
  - Data outputs may retain stale values.
  - flush has priority over output_ready.
- Reset asserted mid-operation: immediate return to reset state; in-flight ops are lost.

Test Plan:
- XLEN=32, STAGES=3. rotate op1=0x12345678 n=8 mb=24 me=31 alter_cr0=1 -> result 0x00000012, cr0=0100, output_valid exactly 3 cycles after accept.
- mask_insert target=0xFFFF0000 op1=0x000000AB n=0 mb=24 me=31 -> 0xFFFF00AB. Wrap mask mb=28 me=3 op1=0xFFFFFFFF -> 0xF000000F.
- sraw op1=0x80000001 n=1 -> 0xC0000000 ca=1. op1=0x80000000 n=4 -> 0xF8000000 ca=0. op1=0x80000000 n=40 -> 0xFFFFFFFF ca=1. All with ca_valid=1.
- slw op1=1 n=32 -> 0, cr0 EQ=1. srw op1=0x80000000 n=31 -> 0x00000001 ca_valid=0. xer_so=1 -> cr0 SO=1.
- 6 back-to-back ops with output_ready low for 5 cycles -> input_ready drops after 3 accepted. Outputs held stable; all 6 delivered in order with correct rs_id_out.
- flush with 2 ops in flight and a third offered -> output_valid 0 next cycle, none of the 3 emerge, a later op completes normally. Repeat with rst pulse -> all outputs 0 immediately.
- XLEN=64: rotate op1=0x0123456789ABCDEF n=4 mb=0 me=63 -> 0x123456789ABCDEF0.
